// File: rtl/imem_loader_pkg.sv
// Shared types and width constants for the instruction-memory byte loader.
package imem_loader_pkg;
  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);
  localparam logic [WORD_W-1:0] BASE_ADDR_DEF = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE,
    ST_CHECK,
    ST_DONE
  } state_e;
endpackage

// File: rtl/imem_loader_if.sv
// Host-side handshake and instruction-memory write bus of the loader.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int LEN_W = 8
);
  logic              load_start;
  logic [LEN_W-1:0]  load_len;
  logic              byte_valid;
  logic [BYTE_W-1:0] byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [WORD_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;

  modport master (
    output load_start, load_len, byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err
  );

  modport slave (
    input  load_start, load_len, byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err
  );
endinterface

// File: rtl/imem_loader_byte_assembler.sv
// Little-endian byte-to-word assembler; o_word/o_last describe the word that
// completes if the current byte is accepted.
module byte_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [BYTE_W-1:0] i_byte,
  output logic              o_last,
  output logic [WORD_W-1:0] o_word
);
  logic [LANE_W-1:0]        r_lane;
  logic [WORD_W-BYTE_W-1:0] r_shift;

  // New bytes enter at the top, so after four shifts byte 0 sits in [7:0].
  assign o_word = {i_byte, r_shift};
  assign o_last = i_en && (r_lane == LANE_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane  <= '0;
      r_shift <= '0;
    end else if (i_clr) begin
      r_lane  <= '0;
    end else if (i_en) begin
      r_lane  <= r_lane + LANE_W'(1);
      r_shift <= o_word[WORD_W-1:BYTE_W];
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory programmer that holds the CPU while loading.
// Optional trailing checksum word enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [WORD_W-1:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter int                LEN_W     = 8
)(
  input  logic clk,
  input  logic rst_n,
  imem_loader_if.slave bus
);
  state_e            r_state;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic [WORD_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic              r_we;
  logic              r_byte_ready;
  logic              r_hold;
  logic              r_done;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] r_sum;
  logic              r_err;
`endif

  logic              w_accept;
  logic              w_start;
  logic              w_last;
  logic [WORD_W-1:0] w_word;
  logic [LEN_W-1:0]  w_cnt_nxt;

  // byte_ready is registered, so acceptance never depends combinationally on byte_valid timing.
  assign w_accept  = bus.byte_valid && r_byte_ready;
  assign w_start   = (r_state == ST_IDLE) && bus.load_start;
  assign w_cnt_nxt = r_cnt + LEN_W'(1);

  byte_assembler u_asm (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_start),
    .i_en   (w_accept),
    .i_byte (bus.byte_data),
    .o_last (w_last),
    .o_word (w_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_len        <= '0;
      r_cnt        <= '0;
      r_addr       <= BASE_ADDR;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_byte_ready <= 1'b0;
      r_hold       <= 1'b0;
      r_done       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum        <= '0;
      r_err        <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.load_start) begin
            r_len  <= bus.load_len;
            r_cnt  <= '0;
            r_addr <= BASE_ADDR;
            r_hold <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum  <= '0;
            r_err  <= 1'b0;
`endif
            if (bus.load_len == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state      <= ST_COLLECT;
              r_byte_ready <= 1'b1;
            end
          end
        end
        ST_COLLECT: begin
          if (w_last) begin
            r_wdata      <= w_word;
            r_we         <= 1'b1;
            r_byte_ready <= 1'b0;
            r_state      <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // Address advances only after the strobe cycle, so imem_addr matches imem_wdata.
          r_we   <= 1'b0;
          r_addr <= r_addr + WORD_W'(4);
          r_cnt  <= w_cnt_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
          r_sum  <= r_sum + r_wdata;
`endif
          if (w_cnt_nxt == r_len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_state      <= ST_CHECK;
            r_byte_ready <= 1'b1;
`else
            r_state      <= ST_DONE;
            r_done       <= 1'b1;
`endif
          end else begin
            r_state      <= ST_COLLECT;
            r_byte_ready <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (w_last) begin
            r_err        <= (w_word != r_sum);
            r_byte_ready <= 1'b0;
            r_done       <= 1'b1;
            r_state      <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          r_done  <= 1'b0;
          r_hold  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_byte_ready <= 1'b0;
          r_we         <= 1'b0;
          r_done       <= 1'b0;
          r_hold       <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.byte_ready = r_byte_ready;
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign bus.cpu_hold   = r_hold;
  assign bus.load_done  = r_done;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign bus.load_err   = r_err;
`else
  assign bus.load_err   = 1'b0;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
module tb_imem_loader;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  imem_loader_if #(.LEN_W(8)) bus();

  imem_loader #(.BASE_ADDR(32'h0000_0000), .LEN_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_we     = 0;
  int   n_done   = 0;
  int   n_acc    = 0;
  int   n_hold_drop = 0;
  logic hold_exp = 1'b0;
  logic acc_now  = 1'b0;
  logic err_at_done = 1'b0;
  wr_t  exp_q[$];
  logic [7:0] tx_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: observe at the falling edge, return 1 time unit after the rising edge.
  task automatic cycle();
    wr_t e;
    @(negedge clk);
    if (bus.imem_we === 1'b1) begin
      n_we++;
      chk("ready_low_in_write", {31'd0, bus.byte_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", bus.imem_addr, 32'hxxxx_xxxx);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", bus.imem_addr, e.addr);
        chk("write_data", bus.imem_wdata, e.data);
      end
    end
    if (bus.load_done === 1'b1) begin
      n_done++;
      err_at_done = bus.load_err;
    end
    acc_now = (bus.byte_valid === 1'b1) && (bus.byte_ready === 1'b1);
    if (acc_now) n_acc++;
    if (hold_exp && (bus.cpu_hold !== 1'b1)) n_hold_drop++;
    @(posedge clk);
    #1;
  endtask

  task automatic push_bytes(input logic [31:0] w);
    for (int i = 0; i < 4; i++) tx_q.push_back(w[8*i +: 8]);
  endtask

  task automatic push_word(input logic [31:0] a, input logic [31:0] w);
    wr_t e;
    e.addr = a;
    e.data = w;
    exp_q.push_back(e);
    push_bytes(w);
  endtask

  task automatic start(input logic [7:0] len);
    bus.load_start = 1'b1;
    bus.load_len   = len;
    cycle();
    bus.load_start = 1'b0;
    hold_exp       = 1'b1;
  endtask

  task automatic send(input bit toggle);
    int budget = 200;
    int ph = 0;
    while (tx_q.size() > 0 && budget > 0) begin
      bus.byte_valid = toggle ? (ph[0] == 1'b0) : 1'b1;
      bus.byte_data  = tx_q[0];
      ph++;
      cycle();
      if (acc_now) void'(tx_q.pop_front());
      budget--;
    end
    bus.byte_valid = 1'b0;
    if (tx_q.size() != 0) begin
      chk("stream_timeout_bytes_left", tx_q.size(), 32'd0);
      tx_q.delete();
    end
  endtask

  task automatic wait_done(input int budget, output int lat);
    int seen = n_done;
    lat = 0;
    while (n_done == seen && budget > 0) begin
      cycle();
      lat++;
      budget--;
    end
    chk("load_done_seen", n_done - seen, 32'd1);
    hold_exp = 1'b0;
    chk("hold_falls_after_done", {31'd0, bus.cpu_hold}, 32'd0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_byte_ready"}, {31'd0, bus.byte_ready}, 32'd0);
    chk({tag, "_imem_we"},    {31'd0, bus.imem_we},    32'd0);
    chk({tag, "_imem_addr"},  bus.imem_addr,           32'h0000_0000);
    chk({tag, "_imem_wdata"}, bus.imem_wdata,          32'h0000_0000);
    chk({tag, "_cpu_hold"},   {31'd0, bus.cpu_hold},   32'd0);
    chk({tag, "_load_done"},  {31'd0, bus.load_done},  32'd0);
    chk({tag, "_load_err"},   {31'd0, bus.load_err},   32'd0);
  endtask

  initial begin
    int lat;
    int we0, done0, acc0;
    bus.load_start = 1'b0;
    bus.load_len   = 8'd0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'd0;

    #2;
    chk_reset_values("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle();

    // Two-word load, bytes streamed back to back.
    we0 = n_we; done0 = n_done; n_hold_drop = 0;
    push_word(32'h0, 32'h0000_0013);
    push_word(32'h4, 32'h0010_0093);
    start(8'd2);
    chk("hold_rises_after_start", {31'd0, bus.cpu_hold}, 32'd1);
    send(1'b0);
    wait_done(20, lat);
    chk("t1_writes", n_we - we0, 32'd2);
    chk("t1_done_pulses", n_done - done0, 32'd1);
    chk("t1_hold_throughout", n_hold_drop, 32'd0);
    chk("t1_err_at_done", {31'd0, err_at_done}, 32'd0);
    chk("t1_scoreboard_empty", exp_q.size(), 32'd0);
    cycle();

    // Zero-length load: immediate done, nothing consumed or written.
    we0 = n_we; acc0 = n_acc; done0 = n_done;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hAA;
    start(8'd0);
    wait_done(4, lat);
    chk("len0_latency_le2", {31'd0, lat <= 2}, 32'd1);
    bus.byte_valid = 1'b0;
    cycle();
    chk("len0_no_write", n_we - we0, 32'd0);
    chk("len0_no_bytes", n_acc - acc0, 32'd0);

    // One-word load with byte_valid toggling.
    we0 = n_we;
    push_word(32'h0, 32'hDEAD_BEEF);
    start(8'd1);
    send(1'b1);
    wait_done(20, lat);
    chk("t3_writes", n_we - we0, 32'd1);
    chk("t3_scoreboard_empty", exp_q.size(), 32'd0);
    cycle();

    // Reset in the middle of a word, then a fresh one-word load.
    we0 = n_we;
    start(8'd1);
    tx_q.push_back(8'h55);
    tx_q.push_back(8'h66);
    send(1'b0);
    rst_n = 1'b0;
    hold_exp = 1'b0;
    #1;
    chk_reset_values("midreset");
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("midreset_no_write", n_we - we0, 32'd0);
    push_word(32'h0, 32'h1122_3344);
    start(8'd1);
    send(1'b0);
    wait_done(20, lat);
    chk("t4_writes", n_we - we0, 32'd1);
    chk("t4_scoreboard_empty", exp_q.size(), 32'd0);
    cycle();

    // load_start while collecting must be ignored.
    we0 = n_we; done0 = n_done;
    begin
      wr_t e;
      e.addr = 32'h0; e.data = 32'hA1B2_C3D4; exp_q.push_back(e);
      e.addr = 32'h4; e.data = 32'h0BAD_F00D; exp_q.push_back(e);
    end
    start(8'd2);
    tx_q.push_back(8'hD4);
    tx_q.push_back(8'hC3);
    send(1'b0);
    bus.load_start = 1'b1;
    bus.load_len   = 8'd5;
    cycle();
    bus.load_start = 1'b0;
    tx_q.push_back(8'hB2);
    tx_q.push_back(8'hA1);
    push_bytes(32'h0BAD_F00D);
    send(1'b0);
    wait_done(20, lat);
    chk("t5_writes", n_we - we0, 32'd2);
    chk("t5_done_pulses", n_done - done0, 32'd1);
    chk("t5_scoreboard_empty", exp_q.size(), 32'd0);
    cycle();

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Matching trailing checksum.
    push_word(32'h0, 32'h0000_0013);
    push_bytes(32'h0000_0013);
    start(8'd1);
    send(1'b0);
    wait_done(20, lat);
    chk("cks_match_err", {31'd0, err_at_done}, 32'd0);
    cycle();

    // Mismatching checksum: sticky until the next accepted start.
    push_word(32'h0, 32'h0000_0013);
    push_bytes(32'h0000_0014);
    start(8'd1);
    send(1'b0);
    wait_done(20, lat);
    chk("cks_mismatch_err", {31'd0, err_at_done}, 32'd1);
    cycle();
    chk("cks_err_sticky", {31'd0, bus.load_err}, 32'd1);
    start(8'd0);
    chk("cks_err_cleared", {31'd0, bus.load_err}, 32'd0);
    wait_done(4, lat);
    cycle();
`endif

    chk("final_scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream programmer for the single-cycle processor's instruction memory: accepts a little-endian byte stream, assembles 32-bit instruction words and writes them at consecutive PC-aligned addresses. While loading it holds the CPU (PC and register updates frozen) so fetch never sees a partially loaded program. Sits between the host/UART byte source and the write port of `InstructionMemory`; the fetch path (PC → instruction) stays unchanged.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_0000, byte address of the first word written; must be 4-aligned
- `LEN_W`, 8, width of the word-count input; a load covers at most 2^LEN_W−1 words

Ports:
- `clk`  in  1  system clock, all logic rising-edge
- `rst_n`  in  1  asynchronous active-low reset
- `load_start`  in  1  one-cycle request to begin a load; sampled only in IDLE
- `load_len`  in  LEN_W  number of words to load, sampled with `load_start`
- `byte_valid`  in  1  source has a byte on `byte_data`
- `byte_data`  in  8  stream byte
- `byte_ready`  out  1  loader accepts a byte this cycle
- `imem_we`  out  1  instruction-memory write strobe
- `imem_addr`  out  32  byte address of the write, 4-aligned
- `imem_wdata`  out  32  instruction word
- `cpu_hold`  out  1  freezes the processor while high
- `load_done`  out  1  one-cycle pulse at end of load
- `load_err`  out  1  checksum mismatch flag (see Configuration)

## Operation
- States: IDLE, COLLECT, WRITE, CHECK (checksum build only), DONE.
- IDLE: `byte_ready`=0, `cpu_hold`=0. On `load_start`=1: latch `load_len`, set word counter to 0, set address to `BASE_ADDR`, clear `load_err`, go to COLLECT. If `load_len`=0, go straight to DONE.
- COLLECT: `byte_ready`=1, `cpu_hold`=1. A byte is accepted when `byte_valid && byte_ready`. Byte k (0..3) goes to word bits [8k+7:8k]. The 4th accepted byte moves the state to WRITE.
- WRITE: `byte_ready`=0. Assert `imem_we`=1 with the registered address/word for exactly one cycle. Then address += 4 and count += 1. If count == latched len, go to CHECK (if enabled) or DONE; otherwise go to COLLECT.
- CHECK: collect 4 bytes like COLLECT, with no write. Compare against the running sum; set `load_err` on mismatch. Go to DONE.
- DONE: `load_done`=1 for one cycle, `cpu_hold`=1 for that cycle. Then go to IDLE.
- `load_start` outside IDLE is ignored. `byte_valid` outside COLLECT/CHECK is ignored, and the byte is not consumed.
- Address arithmetic is modulo 2^32; wrap past 32'hFFFF_FFFC is not flagged.

## Timing
- Reset values: `byte_ready`=0, `imem_we`=0, `imem_addr`=`BASE_ADDR`, `imem_wdata`=0, `cpu_hold`=0, `load_done`=0, `load_err`=0, state IDLE.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- The 4th byte is accepted at edge n; `imem_we` is high during cycle n+1. Minimum throughput is 5 cycles per word.
- `cpu_hold` rises the cycle after `load_start` and falls the cycle after `load_done`.
- Reset asserted mid-load: all registers return to reset values immediately. The partial word is discarded and no write is issued. Words already written stay in memory.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - A 32-bit running sum (mod 2^32) of all written words is kept.
  - After the last word, CHECK consumes 4 extra bytes (little-endian expected sum).
  - `load_err` is set in DONE on mismatch and stays sticky until the next accepted `load_start`.
- Not defined:
  - No CHECK state and no trailing bytes.
  - `load_err` is tied to 0.

## Structure
- Shared package `imem_loader_pkg`: the state enum, the `BASE_ADDR` default, and the word/byte-lane width constants.
- Sub-module `byte_assembler`: shifts in 4 bytes and flags word-complete. It is reused for data words and the checksum word.
- The FSM, counters and checksum accumulator live in the top module.

## Test plan
- Reset, then `load_start` with `load_len`=2, streaming bytes 13,00,00,00,93,00,10,00 with `byte_valid` held high:
  - First write: `imem_addr`=0, `imem_wdata`=32'h0000_0013.
  - Second write: `imem_addr`=4, `imem_wdata`=32'h0010_0093.
  - Then one `load_done` pulse; `cpu_hold` high throughout.
- `load_len`=0 → `load_done` two cycles after `load_start`; no `imem_we`; no bytes consumed.
- `byte_valid` toggled every other cycle during a 1-word load → still exactly one write, with the correct word; `byte_ready` low in WRITE.
- `rst_n` pulled low after 2 of 4 bytes → outputs return to reset values. A following `load_start` with `load_len`=1 writes only the new word at address 0.
- `load_start` pulsed during COLLECT → ignored; word count and address are unaffected.
- With `IMEM_LOADER_CHECKSUM_EN`, 1 word 32'h0000_0013:
  - Trailing 13,00,00,00 → `load_err`=0.
  - Trailing 14,00,00,00 → `load_err`=1, cleared by the next `load_start`.
